vram_scan_arbiter: RTL and testbench



---
 rtl/vram_pkg.sv | 23 ++
 rtl/vram_pix_addr.sv | 34 +++
 rtl/vram_scan_arbiter.sv | 129 ++++++++++++
 tb/tb_vram_scan_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// +----------------------------------------------------------------------+
// | vram_pkg: shared geometry and bus-slot encoding for the VRAM arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vram_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int FB_SIZE  = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN_RD  = 2'd1,
    SCAN_CLR = 2'd2,
    WR       = 2'd3
  } slot_e;

endpackage

`default_nettype wire

// File: rtl/vram_pix_addr.sv
// +----------------------------------------------------------------------+
// | vram_pix_addr: row*H_ACTIVE+col pixel address and framebuffer bound  |
// | check of an arbitrary address. Rev 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module vram_pix_addr #(
  parameter int H_ACTIVE = vram_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vram_pkg::V_ACTIVE,
  parameter int ADDR_W   = vram_pkg::ADDR_W
) (
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              chk_ok
);
  import vram_pkg::*;

  logic [ADDR_W-1:0] w_row_base;

  // 640 = 512 + 128, so the default geometry needs only two shifts and an add
  if (H_ACTIVE == 640) begin : g_shift
    assign w_row_base = (ADDR_W'(row) << 9) + (ADDR_W'(row) << 7);
  end else begin : g_mult
    assign w_row_base = ADDR_W'(row) * ADDR_W'(H_ACTIVE);
  end

  assign addr   = w_row_base + ADDR_W'(col);
  assign chk_ok = ({1'b0, chk_addr} < (ADDR_W+1)'(H_ACTIVE * V_ACTIVE));

endmodule

`default_nettype wire

// File: rtl/vram_scan_arbiter.sv
// +----------------------------------------------------------------------+
// | vram_scan_arbiter: shares the framebuffer RAM between scanout and    |
// | the pixel writer. Optional erase-behind-scan: VRAM_SCAN_ARB_CLEAR_EN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vram_scan_arbiter #(
  parameter int H_ACTIVE = vram_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vram_pkg::V_ACTIVE,
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = vram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [9:0]        col,
  input  logic [8:0]        row,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);
  import vram_pkg::*;

  slot_e             r_state;
  slot_e             w_next;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_wr_ok;
  logic              w_scan_go;
  logic              w_blank_ce;
  logic [ADDR_W-1:0] w_addr_d;
  logic              w_we_d;
  logic [DATA_W-1:0] w_wdata_d;
  logic              r_blk0;
  logic              r_blk1;
  logic              r_rd1;

  vram_pix_addr #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_pix_addr (
    .row      (row),
    .col      (col),
    .chk_addr (wr_addr),
    .addr     (w_scan_addr),
    .chk_ok   (w_wr_ok)
  );

  assign w_scan_go  = pix_ce & ~hblank & ~vblank;
  assign w_blank_ce = pix_ce & (hblank | vblank);

  always_comb begin
    w_next    = IDLE;
    w_addr_d  = mem_addr;
    w_we_d    = 1'b0;
    w_wdata_d = mem_wdata;
`ifdef VRAM_SCAN_ARB_CLEAR_EN
    // Erase the pixel just read, reusing the address still on the bus
    if (r_state == SCAN_RD) begin
      w_next    = SCAN_CLR;
      w_we_d    = 1'b1;
      w_wdata_d = '0;
    end else
`endif
    if (w_scan_go) begin
      w_next   = SCAN_RD;
      w_addr_d = w_scan_addr;
    end else if (wr_req && !wr_ack) begin
      // Masking on wr_ack keeps a held request from being granted twice
      w_next    = WR;
      w_addr_d  = wr_addr;
      w_we_d    = w_wr_ok;
      w_wdata_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      r_state   <= w_next;
      mem_addr  <= w_addr_d;
      mem_we    <= w_we_d;
      mem_wdata <= w_wdata_d;
      wr_ack    <= (w_next == WR);
    end
  end

  // Blank pixels travel the same two-edge path as real reads to stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk0    <= 1'b0;
      r_blk1    <= 1'b0;
      r_rd1     <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      r_blk0 <= w_blank_ce;
      r_blk1 <= r_blk0;
      r_rd1  <= (r_state == SCAN_RD);
      if (r_rd1) begin
        pix_data  <= mem_rdata;
        pix_valid <= 1'b1;
      end else if (r_blk1) begin
        pix_data  <= '0;
        pix_valid <= 1'b1;
      end else begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_scan_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_vram_scan_arbiter: directed self-checking bench for the arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vram_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic        hblank;
  logic        vblank;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic [3:0]  pix_data;
  logic        pix_valid;

  int n_cmp = 0;
  int n_bad = 0;

  vram_scan_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .pix_ce    (pix_ce),
    .hblank    (hblank),
    .vblank    (vblank),
    .col       (col),
    .row       (row),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pix_ce = 1'b0; hblank = 1'b0; vblank = 1'b0;
    col = '0; row = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; mem_rdata = '0;

    // reset state
    cyc();
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_wr_ack", wr_ack, 0);
    check_eq("rst_pix_valid", pix_valid, 0);
    check_eq("rst_pix_data", pix_data, 0);
    rst = 1'b0;
    cyc();
    cyc();
    check_eq("idle_mem_we", mem_we, 0);

    // scanout row 1 col 5 -> addr 645, data returns two edges later
    row = 9'd1; col = 10'd5; pix_ce = 1'b1; mem_rdata = 4'hA;
    cyc();
    check_eq("scan_addr", mem_addr, 645);
    check_eq("scan_we", mem_we, 0);
    pix_ce = 1'b0;
    cyc();
    check_eq("scan_e1_valid", pix_valid, 0);
`ifdef VRAM_SCAN_ARB_CLEAR_EN
    check_eq("clr_we", mem_we, 1);
    check_eq("clr_addr", mem_addr, 645);
    check_eq("clr_wdata", mem_wdata, 0);
`else
    check_eq("scan_e1_we", mem_we, 0);
`endif
    cyc();
    check_eq("scan_pix_valid", pix_valid, 1);
    check_eq("scan_pix_data", pix_data, 4'hA);
    cyc();
    check_eq("scan_pix_valid_end", pix_valid, 0);

    // last pixel of the frame
    row = 9'd479; col = 10'd639; pix_ce = 1'b1;
    cyc();
    check_eq("scan_last_addr", mem_addr, 307199);
    pix_ce = 1'b0;
    cyc();
    cyc();
    cyc();

    // contention: scan read at addr 100 and writer request on the same edge
    row = 9'd0; col = 10'd100; pix_ce = 1'b1;
    wr_req = 1'b1; wr_addr = 19'd1000; wr_data = 4'h7;
    cyc();
    check_eq("cont_scan_addr", mem_addr, 100);
    check_eq("cont_scan_we", mem_we, 0);
    check_eq("cont_scan_ack", wr_ack, 0);
    pix_ce = 1'b0;
    cyc();
`ifdef VRAM_SCAN_ARB_CLEAR_EN
    check_eq("cont_clr_we", mem_we, 1);
    check_eq("cont_clr_addr", mem_addr, 100);
    check_eq("cont_clr_wdata", mem_wdata, 0);
    check_eq("cont_clr_ack", wr_ack, 0);
    for (int i = 0; i < 4; i++) begin
      pix_ce = (i % 2 == 0);
      cyc();
      check_eq("lockout_ack", wr_ack, 0);
    end
    hblank = 1'b1; pix_ce = 1'b1;
    cyc();
`endif
    check_eq("wr_ack", wr_ack, 1);
    check_eq("wr_we", mem_we, 1);
    check_eq("wr_addr", mem_addr, 1000);
    check_eq("wr_wdata", mem_wdata, 7);
    wr_req = 1'b0; pix_ce = 1'b0; hblank = 1'b0;
    cyc();
    check_eq("wr_ack_pulse", wr_ack, 0);
    check_eq("wr_we_end", mem_we, 0);
    cyc();

    // out-of-range write is acked but dropped
    wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 4'h3;
    cyc();
    check_eq("oor_ack", wr_ack, 1);
    check_eq("oor_we", mem_we, 0);
    wr_req = 1'b0;
    cyc();
    check_eq("oor_ack_end", wr_ack, 0);
    cyc();
    cyc();

    // vblank: black pixels, no reads, writer acked every other clk
    vblank = 1'b1; mem_rdata = 4'hF;
    wr_req = 1'b1; wr_addr = 19'd2000; wr_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      pix_ce = (i % 2 == 0);
      cyc();
      check_eq("blank_ack", wr_ack, (i % 2 == 0));
      check_eq("blank_we", mem_we, (i % 2 == 0));
      if (i >= 2) begin
        check_eq("blank_pix_valid", pix_valid, (i % 2 == 0));
        check_eq("blank_pix_data", pix_data, 0);
      end
    end

    // asynchronous reset in the middle of a granted write
    pix_ce = 1'b1;
    cyc();
    check_eq("pre_rst_we", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_we", mem_we, 0);
    check_eq("async_rst_ack", wr_ack, 0);
    check_eq("async_rst_addr", mem_addr, 0);
    check_eq("async_rst_valid", pix_valid, 0);
    rst = 1'b0; wr_req = 1'b0; pix_ce = 1'b0; vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("post_rst_we", mem_we, 0);
    end

    // writer re-requests after reset
    wr_req = 1'b1; wr_addr = 19'd42; wr_data = 4'h9;
    cyc();
    check_eq("rereq_ack", wr_ack, 1);
    check_eq("rereq_addr", mem_addr, 42);
    check_eq("rereq_wdata", mem_wdata, 9);
    wr_req = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
